dot_eater: RTL and testbench
============================

Name: dot_eater

Overview:
- Consumer/controller side of the dot bank: samples the bank's alive_10 vector, compares the player position against every dot position once per scan, and drives one-cycle kill_10 pulses back into the bank.
- Confirms each kill by watching the alive bit drop, then credits the score.
- Sits between player movement logic and the dot bank; feeds the score display and the level-clear logic.

Parameters:
- N_DOTS, 10, number of dots in the bank (width of alive/kill vectors)
- COORD_W, 10, width of one X or Y coordinate
- HIT_RADIUS, 4, max per-axis distance (inclusive) counted as a hit
- POINTS, 10, score increment per confirmed kill (≤99)
- SCORE_W, 16, score register width
- ACK_TIMEOUT, 3, WAIT_ACK cycles allowed before a kill is abandoned

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- scan_start  in  1  single-cycle request to scan all dots (typically once per frame)
- player_x  in  COORD_W  player X position
- player_y  in  COORD_W  player Y position
- dot_x_flat  in  N_DOTS*COORD_W  dot i X at [i*COORD_W +: COORD_W]
- dot_y_flat  in  N_DOTS*COORD_W  dot i Y, same packing
- alive_10  in  N_DOTS  alive status from dot bank
- kill_10  out  N_DOTS  registered kill pulses to dot bank, at most one bit high
- score  out  SCORE_W  accumulated score
- eat_pulse  out  1  high one cycle per confirmed kill
- busy  out  1  high in any state other than IDLE
- scan_done  out  1  high one cycle at end of each scan
- all_eaten  out  1  registered (alive_10 == 0)
- ack_err  out  1  sticky, set on kill timeout

Behaviour:
- Interface: one clock Clk. Reset is synchronous and active-high.
- Reset values: FSM = IDLE, idx = 0, kill_10 = 0, score = 0, eat_pulse = 0, scan_done = 0, ack_err = 0, all_eaten = 0, timeout counter = 0. Reset overrides everything, including mid-scan and mid-kill. A kill bit high in the reset cycle is low after the reset edge.
- IDLE: on scan_start, set idx = 0 and go to SCAN. scan_start while busy is ignored (not queued).
- SCAN (one cycle per dot): hit = alive_10[idx] && |player_x − dot_x[idx]| ≤ HIT_RADIUS && |player_y − dot_y[idx]| ≤ HIT_RADIUS.
  - Compute absolute differences on unsigned COORD_W+1-bit values, with no wrap-around.
  - Positions are sampled live in each SCAN cycle.
  - On hit: register kill_10[idx] = 1 and go to KILL.
  - On no hit: if idx == N_DOTS−1 go to DONE, else idx++.
- KILL: kill_10[idx] is high for exactly this cycle. Clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - If alive_10[idx] == 0: score += POINTS, eat_pulse = 1 for one cycle, then advance (idx++ → SCAN, or DONE if idx was last).
  - Else increment the timeout counter. When the counter reaches ACK_TIMEOUT: set ack_err, give no score, advance the same way.
- DONE: scan_done = 1 for one cycle, then IDLE.
- Latency:
  - Scan with no hits: N_DOTS SCAN cycles + 1 DONE cycle, so scan_done asserts N_DOTS+1 cycles after the cycle following scan_start.
  - Each acknowledged hit adds 2 cycles (KILL + WAIT_ACK).
- Score saturates at all-ones (binary mode). It never wraps.
- all_eaten is updated every cycle regardless of FSM state. It is low after reset until the first sample.
- A dot already dead at SCAN is never killed and never scored. Multiple overlapping dots are each killed sequentially in the same scan.

Optional Feature:
- Macro: DOT_EATER_SCORE_BCD_EN.
- Defined: score is 4 packed BCD digits (SCORE_W forced to 16). POINTS is added as a decimal value with per-digit carry. Score saturates at 9999 (16'h9999).
- Undefined: plain binary score that saturates at 2^SCORE_W−1.
- FSM, timing and all other ports are identical in both builds.

Test Plan:
- Reset, then scan_start with all alive_10 = 0 → no kill bits; scan_done 12 cycles after scan_start (1 cycle into SCAN + 10 SCAN + 1 DONE); score = 0; all_eaten = 1.
- Player (100,100), dot 3 at (103,96), alive = 10'h3FF, real dot model → only kill_10[3] pulses for one cycle; eat_pulse once; score = 10; scan_done 14 cycles after scan_start.
- Same position, dot 3 at (105,100) (dx = 5 > 4) → no kill, score unchanged.
- Dots 2 and 7 both within radius → two separate single-bit kill pulses in order 2 then 7; score = 20; alive = 10'h37B afterwards.
- Bank model ignores kill on dot 5 → after 3 WAIT_ACK cycles ack_err = 1, score unchanged, scan still completes with scan_done.
- Reset asserted during KILL → kill_10 = 0 after that edge, score = 0, FSM IDLE. With DOT_EATER_SCORE_BCD_EN defined, 3 kills starting from score 16'h0095 → 16'h0125.

Source files
------------

// File: rtl/dot_eater.sv
// rtl/dot_eater.sv - dot bank consumer: scans dots, pulses kills, confirms them, keeps score.
// Optional DOT_EATER_SCORE_BCD_EN: 4-digit packed BCD score saturating at 9999.
module dot_eater #(
  parameter int N_DOTS      = 10,
  parameter int COORD_W     = 10,
  parameter int HIT_RADIUS  = 4,
  parameter int POINTS      = 10,
  parameter int SCORE_W     = 16,
  parameter int ACK_TIMEOUT = 3,
`ifdef DOT_EATER_SCORE_BCD_EN
  localparam int SW = 16
`else
  localparam int SW = SCORE_W
`endif
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        scan_start,
  input  logic [COORD_W-1:0]          player_x,
  input  logic [COORD_W-1:0]          player_y,
  input  logic [N_DOTS*COORD_W-1:0]   dot_x_flat,
  input  logic [N_DOTS*COORD_W-1:0]   dot_y_flat,
  input  logic [N_DOTS-1:0]           alive_10,
  output logic [N_DOTS-1:0]           kill_10,
  output logic [SW-1:0]               score,
  output logic                        eat_pulse,
  output logic                        busy,
  output logic                        scan_done,
  output logic                        all_eaten,
  output logic                        ack_err
);

  localparam int IDX_W = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_KILL, S_WAIT, S_DONE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [N_DOTS-1:0]   kill_q;
  logic [SW-1:0]       score_q, score_d;
  logic                eat_q, done_q, all_q, err_q;

  logic [COORD_W-1:0]  dot_x, dot_y;
  logic [COORD_W:0]    px_e, py_e, dx_e, dy_e, dist_x, dist_y;
  logic                hit, last;

`ifdef DOT_EATER_SCORE_BCD_EN
  function automatic logic [15:0] bcd_add(input logic [15:0] a);
    logic [15:0] b, r;
    logic [4:0]  s;
    logic        c;
    b = {8'h00, 4'(POINTS / 10), 4'(POINTS % 10)};
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        r[i*4 +: 4] = s[3:0] + 4'd6;
        c = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return c ? 16'h9999 : r;
  endfunction
`endif

  always_comb begin
    dot_x  = dot_x_flat[idx_q*COORD_W +: COORD_W];
    dot_y  = dot_y_flat[idx_q*COORD_W +: COORD_W];
    // widen before subtracting so the distance never wraps across the coordinate range
    px_e   = {1'b0, player_x};
    py_e   = {1'b0, player_y};
    dx_e   = {1'b0, dot_x};
    dy_e   = {1'b0, dot_y};
    dist_x = (px_e >= dx_e) ? (px_e - dx_e) : (dx_e - px_e);
    dist_y = (py_e >= dy_e) ? (py_e - dy_e) : (dy_e - py_e);
    hit    = alive_10[idx_q] &&
             (dist_x <= (COORD_W+1)'(HIT_RADIUS)) &&
             (dist_y <= (COORD_W+1)'(HIT_RADIUS));
    last   = (idx_q == IDX_W'(N_DOTS - 1));
    tmo_d  = tmo_q + 1'b1;
  end

`ifdef DOT_EATER_SCORE_BCD_EN
  always_comb score_d = bcd_add(score_q);
`else
  logic [SW:0] score_sum;
  always_comb begin
    score_sum = {1'b0, score_q} + (SW+1)'(POINTS);
    score_d   = score_sum[SW] ? {SW{1'b1}} : score_sum[SW-1:0];
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      kill_q  <= '0;
      score_q <= '0;
      eat_q   <= 1'b0;
      done_q  <= 1'b0;
      all_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      kill_q <= '0;
      eat_q  <= 1'b0;
      done_q <= 1'b0;
      all_q  <= (alive_10 == '0);
      case (state_q)
        S_IDLE: begin
          if (scan_start) begin
            idx_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit) begin
            kill_q[idx_q] <= 1'b1;
            state_q       <= S_KILL;
          end else if (last) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_KILL: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!alive_10[idx_q] || (tmo_d == CNT_W'(ACK_TIMEOUT))) begin
            if (!alive_10[idx_q]) begin
              score_q <= score_d;
              eat_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            if (last) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_SCAN;
            end
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign kill_10   = kill_q;
  assign score     = score_q;
  assign eat_pulse = eat_q;
  assign busy      = (state_q != S_IDLE);
  assign scan_done = done_q;
  assign all_eaten = all_q;
  assign ack_err   = err_q;

endmodule

// File: tb/tb_dot_eater.sv
// tb/tb_dot_eater.sv - self-checking bench for dot_eater with a dot bank model and kill scoreboard.
module tb_dot_eater;

  localparam int N   = 10;
  localparam int CW  = 10;
  localparam int PTS = 10;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            scan_start = 1'b0;
  logic [CW-1:0]   player_x = '0;
  logic [CW-1:0]   player_y = '0;
  logic [N*CW-1:0] dot_x_flat = '0;
  logic [N*CW-1:0] dot_y_flat = '0;
  logic [N-1:0]    alive_10;
  logic [N-1:0]    kill_10;
  logic [15:0]     score;
  logic            eat_pulse, busy, scan_done, all_eaten, ack_err;

  logic [N-1:0]    bank_q;
  logic [N-1:0]    load_val = '0;
  logic [N-1:0]    ign_mask = '0;
  logic            load_en = 1'b1;
  bit              sb_en = 1'b1;

  int checks = 0;
  int failures = 0;
  int total = 0;
  int eat_total = 0;
  int sb_q[$];
  int sb_exp;
  logic [N-1:0] prev_kill = '0;

  typedef struct {
    logic [N-1:0] hit;
    logic [N-1:0] miss;
    logic [N-1:0] alive0;
    logic [N-1:0] ign;
    logic [N-1:0] kills;
    int           lat;
    int           pts;
    logic         err;
    logic [N-1:0] alive_end;
  } vec_t;

  vec_t vecs[7];

  dot_eater dut (
    .Clk(Clk), .Reset(Reset), .scan_start(scan_start),
    .player_x(player_x), .player_y(player_y),
    .dot_x_flat(dot_x_flat), .dot_y_flat(dot_y_flat),
    .alive_10(alive_10), .kill_10(kill_10), .score(score),
    .eat_pulse(eat_pulse), .busy(busy), .scan_done(scan_done),
    .all_eaten(all_eaten), .ack_err(ack_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (load_en) bank_q <= load_val;
    else         bank_q <= bank_q & ~(kill_10 & ~ign_mask);
  end
  assign alive_10 = bank_q;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // scoreboard: every observed kill pulse must match the next expected dot index
  always @(negedge Clk) begin
    if (!Reset) begin
      if (eat_pulse) eat_total++;
      if (sb_en && kill_10 != '0) begin
        check("kill_single_cycle", {22'b0, prev_kill}, 32'h0);
        if (sb_q.size() == 0) begin
          check("kill_unexpected", {22'b0, kill_10}, 32'h0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("kill_onehot", {22'b0, kill_10}, 32'h1 << sb_exp);
        end
      end
    end
    prev_kill = kill_10;
  end

  function automatic logic [15:0] exp_score(input int t);
`ifdef DOT_EATER_SCORE_BCD_EN
    int v;
    v = (t > 9999) ? 9999 : t;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
    return (t > 65535) ? 16'hFFFF : 16'(t);
`endif
  endfunction

  task automatic set_dots(input int px, input int py, input logic [N-1:0] hit, input logic [N-1:0] miss);
    player_x = CW'(px);
    player_y = CW'(py);
    for (int i = 0; i < N; i++) begin
      if (hit[i]) begin
        dot_x_flat[i*CW +: CW] = CW'(px + 3);
        dot_y_flat[i*CW +: CW] = CW'(py - 4);
      end else if (miss[i]) begin
        dot_x_flat[i*CW +: CW] = CW'(px + 5);
        dot_y_flat[i*CW +: CW] = CW'(py);
      end else begin
        dot_x_flat[i*CW +: CW] = CW'(500 + i * 40);
        dot_y_flat[i*CW +: CW] = CW'(500);
      end
    end
  endtask

  task automatic do_scan(input string nm, input logic [N-1:0] a0, input logic [N-1:0] ign,
                         input logic [N-1:0] kills, input int lat_exp, input int pts,
                         input logic err_exp, input logic [N-1:0] alive_exp,
                         input int restart_at, input bit full);
    int  lat;
    int  eat0;
    bit  got;
    load_val = a0;
    load_en  = 1'b1;
    @(posedge Clk);
    #1;
    load_en  = 1'b0;
    ign_mask = ign;
    if (sb_en) begin
      for (int i = 0; i < N; i++) if (kills[i]) sb_q.push_back(i);
    end
    total += pts;
    eat0 = eat_total;
    scan_start = 1'b1;
    lat = 0;
    got = 1'b0;
    while (lat < 60 && !got) begin
      @(posedge Clk);
      #1;
      lat++;
      scan_start = (restart_at == lat);
      @(negedge Clk);
      got = scan_done;
    end
    scan_start = 1'b0;
    if (full) begin
      check({nm, "_done_seen"}, {31'b0, got}, 32'h1);
      check({nm, "_latency"}, lat, lat_exp);
      check({nm, "_score"}, {16'b0, score}, {16'b0, exp_score(total)});
      check({nm, "_eats"}, eat_total - eat0, pts / PTS);
      check({nm, "_ack_err"}, {31'b0, ack_err}, {31'b0, err_exp});
      check({nm, "_alive"}, {22'b0, bank_q}, {22'b0, alive_exp});
      check({nm, "_all_eaten"}, {31'b0, all_eaten}, {31'b0, (alive_exp == '0)});
      check({nm, "_busy"}, {31'b0, busy}, 32'h0);
      check({nm, "_sb_empty"}, sb_q.size(), 0);
    end
    sb_q.delete();
  endtask

  initial begin
    bit found;
    vecs[0] = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 12, 0,  1'b0, 10'h000};
    vecs[1] = '{10'h008, 10'h000, 10'h3FF, 10'h000, 10'h008, 14, 10, 1'b0, 10'h3F7};
    vecs[2] = '{10'h000, 10'h008, 10'h3FF, 10'h000, 10'h000, 12, 0,  1'b0, 10'h3FF};
    vecs[3] = '{10'h084, 10'h000, 10'h3FF, 10'h000, 10'h084, 16, 20, 1'b0, 10'h37B};
    vecs[4] = '{10'h008, 10'h000, 10'h3F7, 10'h000, 10'h000, 12, 0,  1'b0, 10'h3F7};
    vecs[5] = '{10'h201, 10'h000, 10'h3FF, 10'h000, 10'h201, 16, 20, 1'b0, 10'h1FE};
    vecs[6] = '{10'h020, 10'h000, 10'h3FF, 10'h020, 10'h020, 16, 0,  1'b1, 10'h3FF};

    repeat (3) @(posedge Clk);
    #1;
    check("rst_kill", {22'b0, kill_10}, 32'h0);
    check("rst_score", {16'b0, score}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_scan_done", {31'b0, scan_done}, 32'h0);
    check("rst_eat", {31'b0, eat_pulse}, 32'h0);
    check("rst_ack_err", {31'b0, ack_err}, 32'h0);
    check("rst_all_eaten", {31'b0, all_eaten}, 32'h0);
    Reset   = 1'b0;
    load_en = 1'b0;

    for (int v = 0; v < 7; v++) begin
      set_dots(100, 100, vecs[v].hit, vecs[v].miss);
      do_scan($sformatf("vec%0d", v), vecs[v].alive0, vecs[v].ign, vecs[v].kills,
              vecs[v].lat, vecs[v].pts, vecs[v].err, vecs[v].alive_end, 0, 1'b1);
    end

    set_dots(100, 100, 10'h000, 10'h000);
    do_scan("restart_ignored", 10'h3FF, 10'h000, 10'h000, 12, 0, 1'b1, 10'h3FF, 5, 1'b1);
    repeat (3) @(negedge Clk);
    check("restart_no_rescan", {31'b0, busy}, 32'h0);

    set_dots(0, 0, 10'h000, 10'h000);
    dot_x_flat[4*CW +: CW] = 10'd1020;
    dot_y_flat[4*CW +: CW] = 10'd2;
    do_scan("no_wrap", 10'h3FF, 10'h000, 10'h000, 12, 0, 1'b1, 10'h3FF, 0, 1'b1);

    // reset in the middle of a kill
    set_dots(100, 100, 10'h008, 10'h000);
    load_val = 10'h3FF;
    load_en  = 1'b1;
    @(posedge Clk);
    #1;
    load_en = 1'b0;
    sb_q.push_back(3);
    scan_start = 1'b1;
    @(posedge Clk);
    #1;
    scan_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge Clk);
      found = (kill_10 != '0);
    end
    check("rk_kill_seen", {31'b0, found}, 32'h1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rk_kill", {22'b0, kill_10}, 32'h0);
    check("rk_score", {16'b0, score}, 32'h0);
    check("rk_busy", {31'b0, busy}, 32'h0);
    check("rk_ack_err", {31'b0, ack_err}, 32'h0);
    Reset = 1'b0;
    total = 0;
    sb_q.delete();

    set_dots(100, 100, 10'h3FF, 10'h000);
    do_scan("ten_kills", 10'h3FF, 10'h000, 10'h3FF, 32, 100, 1'b0, 10'h000, 0, 1'b1);
    sb_en = 1'b0;
`ifdef DOT_EATER_SCORE_BCD_EN
    for (int s = 0; s < 100; s++)
`else
    for (int s = 0; s < 656; s++)
`endif
      do_scan("sat", 10'h3FF, 10'h000, 10'h3FF, 32, 100, 1'b0, 10'h000, 0, 1'b0);
`ifdef DOT_EATER_SCORE_BCD_EN
    check("sat_score", {16'b0, score}, 32'h9999);
`else
    check("sat_score", {16'b0, score}, 32'hFFFF);
`endif
    check("sat_busy", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
